// File: rtl/l1_dcache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache with whole-line fills and write-backs.
// Define L1_DCACHE_SNOOP_INV_EN to honour snoop_inv; otherwise snoop inputs are ignored.
module l1_dcache_dm #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CHUNKS_LOG = 3,
  parameter int unsigned SETS_LOG   = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  input  logic [DATA_WIDTH/8-1:0]             req_wstrb,
  output logic                                resp_valid,
  output logic [DATA_WIDTH-1:0]               resp_rdata,
  output logic                                mem_cmd_valid,
  output logic                                mem_cmd_store,
  output logic                                mem_cmd_rready,
  output logic [ADDR_WIDTH-1:0]               mem_cmd_addr,
  output logic [DATA_WIDTH*2**CHUNKS_LOG-1:0] mem_cmd_data,
  input  logic                                mem_bus_valid,
  input  logic                                mem_bus_ready,
  input  logic [DATA_WIDTH*2**CHUNKS_LOG-1:0] mem_bus_data,
  input  logic                                snoop_inv,
  input  logic [ADDR_WIDTH-1:0]               snoop_inv_addr
);
  localparam int unsigned Bytes  = DATA_WIDTH / 8;
  localparam int unsigned ByteW  = $clog2(Bytes);
  localparam int unsigned OffW   = CHUNKS_LOG + ByteW;
  localparam int unsigned TagW   = ADDR_WIDTH - OffW - SETS_LOG;
  localparam int unsigned Sets   = 1 << SETS_LOG;
  localparam int unsigned LineW  = DATA_WIDTH << CHUNKS_LOG;

  typedef enum logic [2:0] {
    StIdle, StLookup, StWbReq, StWbWait, StFillReq, StFillWait, StRefill
  } state_e;

  state_e                  state_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [Bytes-1:0]        wstrb_q;
  logic [LineW-1:0]        fill_q;
  logic                    wb_low_q;
  logic [Sets-1:0]         valid_q;
  logic [Sets-1:0]         dirty_q;
  logic [LineW-1:0]        data_q [Sets];
  logic [TagW-1:0]         tag_q  [Sets];

  logic [SETS_LOG-1:0]     idx;
  logic [TagW-1:0]         tag;
  logic [CHUNKS_LOG-1:0]   word_sel;
  logic [LineW-1:0]        line_cur;
  logic [LineW-1:0]        merged_line;
  logic [DATA_WIDTH-1:0]   cur_word;
  logic                    inv_hit_now;
  logic                    hit;
  logic                    victim_dirty;
  logic                    unused_bits;

  assign idx      = addr_q[OffW +: SETS_LOG];
  assign tag      = addr_q[ADDR_WIDTH-1 -: TagW];
  assign word_sel = addr_q[ByteW +: CHUNKS_LOG];
  assign line_cur = data_q[idx];
  assign cur_word = line_cur[word_sel*DATA_WIDTH +: DATA_WIDTH];

`ifdef L1_DCACHE_SNOOP_INV_EN
  logic [SETS_LOG-1:0] s_idx;
  logic [TagW-1:0]     s_tag;
  logic                snoop_kill;

  assign s_idx       = snoop_inv_addr[OffW +: SETS_LOG];
  assign s_tag       = snoop_inv_addr[ADDR_WIDTH-1 -: TagW];
  assign snoop_kill  = snoop_inv && valid_q[s_idx] && (tag_q[s_idx] == s_tag);
  // A snoop killing the indexed line also drops its dirty data: no write-back.
  assign inv_hit_now = snoop_kill && (s_idx == idx);
  assign unused_bits = ^{addr_q[ByteW-1:0], snoop_inv_addr[OffW-1:0]};
`else
  assign inv_hit_now = 1'b0;
  assign unused_bits = ^{addr_q[ByteW-1:0], snoop_inv, snoop_inv_addr};
`endif

  assign hit          = valid_q[idx] && (tag_q[idx] == tag) && !inv_hit_now;
  assign victim_dirty = valid_q[idx] && dirty_q[idx] && !inv_hit_now;

  always_comb begin
    merged_line = line_cur;
    for (int b = 0; b < Bytes; b++) begin
      if (wstrb_q[b]) merged_line[word_sel*DATA_WIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = (state_q == StLookup) && hit;
  assign resp_rdata     = (resp_valid && !write_q) ? cur_word : '0;
  assign mem_cmd_valid  = (state_q == StWbReq) || (state_q == StFillReq);
  assign mem_cmd_store  = (state_q == StWbReq);
  assign mem_cmd_rready = (state_q == StFillWait);
  assign mem_cmd_data   = (state_q == StWbReq) ? line_cur : '0;

  always_comb begin
    mem_cmd_addr = '0;
    if (state_q == StWbReq)   mem_cmd_addr = {tag_q[idx], idx, {OffW{1'b0}}};
    if (state_q == StFillReq) mem_cmd_addr = {tag, idx, {OffW{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      fill_q   <= '0;
      wb_low_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
`ifdef L1_DCACHE_SNOOP_INV_EN
      if (snoop_kill) begin
        valid_q[s_idx] <= 1'b0;
        dirty_q[s_idx] <= 1'b0;
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            if (write_q) dirty_q[idx] <= 1'b1;
            state_q <= StIdle;
          end else if (victim_dirty) begin
            state_q <= StWbReq;
          end else begin
            state_q <= StFillReq;
          end
        end
        StWbReq: begin
          if (mem_bus_ready) begin
            wb_low_q <= 1'b0;
            state_q  <= StWbWait;
          end
        end
        StWbWait: begin
          // Write completion is signalled by ready dropping and then returning.
          if (!mem_bus_ready) begin
            wb_low_q <= 1'b1;
          end else if (wb_low_q) begin
            dirty_q[idx] <= 1'b0;
            state_q      <= StFillReq;
          end
        end
        StFillReq: begin
          if (mem_bus_ready) state_q <= StFillWait;
        end
        StFillWait: begin
          if (mem_bus_valid) begin
            fill_q  <= mem_bus_data;
            state_q <= StRefill;
          end
        end
        StRefill: begin
          // Placed after the snoop clear so a same-cycle snoop loses to the fill.
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          state_q      <= StLookup;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StLookup && hit && write_q) data_q[idx] <= merged_line;
    if (state_q == StRefill) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_l1_dcache_dm.sv
// Self-checking bench for l1_dcache_dm: scoreboarded responses and bus commands against a
// word-level reference memory and a simple line-granular bus model.
module tb_l1_dcache_dm;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid, req_ready, req_write;
  logic [63:0]  req_addr, req_wdata;
  logic [7:0]   req_wstrb;
  logic         resp_valid;
  logic [63:0]  resp_rdata;
  logic         mem_cmd_valid, mem_cmd_store, mem_cmd_rready;
  logic [63:0]  mem_cmd_addr;
  logic [511:0] mem_cmd_data;
  logic         mem_bus_valid, mem_bus_ready;
  logic [511:0] mem_bus_data;
  logic         snoop_inv;
  logic [63:0]  snoop_inv_addr;

  always #5 clk = ~clk;

  l1_dcache_dm dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_store(mem_cmd_store),
    .mem_cmd_rready(mem_cmd_rready), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data),
    .mem_bus_valid(mem_bus_valid), .mem_bus_ready(mem_bus_ready), .mem_bus_data(mem_bus_data),
    .snoop_inv(snoop_inv), .snoop_inv_addr(snoop_inv_addr)
  );

  typedef struct {bit is_load; logic [63:0] data;} resp_t;
  typedef struct {bit store; logic [63:0] addr;} cmd_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  int cmd_cnt = 0;
  bit chk_cmds = 1'b1;
  bit stall_fill = 1'b0;
  bit abort_fill = 1'b0;
  resp_t resp_q[$];
  cmd_t  cmd_q[$];
  logic [511:0] bus_mem [logic [63:0]];
  logic [63:0]  ref_w   [logic [63:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input logic [63:0] a);
    if (a == 64'h1000) return 64'hAAAA;
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  function automatic logic [511:0] bus_line(input logic [63:0] la);
    logic [511:0] l;
    if (bus_mem.exists(la)) return bus_mem[la];
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = init_word(la + 64'(w * 8));
    return l;
  endfunction

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    logic [63:0]  wa;
    logic [511:0] l;
    wa = {a[63:3], 3'b000};
    if (ref_w.exists(wa)) return ref_w[wa];
    l = bus_line({wa[63:6], 6'b0});
    return l[wa[5:3]*64 +: 64];
  endfunction

  function automatic logic [511:0] ref_line(input logic [63:0] la);
    logic [511:0] l;
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = ref_word(la + 64'(w * 8));
    return l;
  endfunction

  function automatic cmd_t mk_cmd(input bit st, input logic [63:0] a);
    cmd_t c;
    c.store = st;
    c.addr  = a;
    return c;
  endfunction

  // Bus model: accepts commands, checks them against the expected queue, serves fills.
  initial begin
    cmd_t c;
    logic [63:0]  la;
    logic [511:0] d;
    bit st;
    mem_bus_ready = 1'b1;
    mem_bus_valid = 1'b0;
    mem_bus_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_cmd_valid && mem_bus_ready) begin
        cmd_cnt++;
        if (chk_cmds) begin
          n_cmp++;
          if (cmd_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_cmd: got store=%0b addr=%h, required no command",
                     mem_cmd_store, mem_cmd_addr);
          end else begin
            c = cmd_q.pop_front();
            if (mem_cmd_store !== c.store || mem_cmd_addr !== c.addr) begin
              n_bad++;
              $display("FAIL cmd: got store=%0b addr=%h, required store=%0b addr=%h",
                       mem_cmd_store, mem_cmd_addr, c.store, c.addr);
            end
          end
        end
        if (mem_cmd_store) begin
          n_cmp++;
          if (mem_cmd_data !== ref_line(mem_cmd_addr)) begin
            n_bad++;
            $display("FAIL wb_data @%h: got %h, required %h", mem_cmd_addr, mem_cmd_data,
                     ref_line(mem_cmd_addr));
          end
        end
        la = mem_cmd_addr;
        st = mem_cmd_store;
        d  = mem_cmd_data;
        @(posedge clk);
        #1 mem_bus_ready = 1'b0;
        if (st) begin
          bus_mem[la] = d;
          repeat (2) @(posedge clk);
          #1;
        end else begin
          repeat (2) @(posedge clk);
          while (stall_fill) @(posedge clk);
          #1;
          if (!abort_fill) begin
            mem_bus_valid = 1'b1;
            mem_bus_data  = bus_line(la);
            @(posedge clk);
            #1 mem_bus_valid = 1'b0;
          end
        end
        mem_bus_ready = 1'b1;
      end
    end
  end

  // Response scoreboard.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        n_cmp++;
        last_resp_cyc = cyc;
        if (resp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h, required no response",
                   resp_rdata);
        end else begin
          r = resp_q.pop_front();
          if (r.is_load && resp_rdata !== r.data) begin
            n_bad++;
            $display("FAIL load_data: got %h, required %h", resp_rdata, r.data);
          end
        end
      end
    end
  end

  task automatic do_req(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [7:0] ws, input bit snp, input logic [63:0] snp_a,
                        output int lat);
    resp_t r;
    logic [63:0] wa, nw;
    int guard, acc;
    lat = -1;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_wait: got 0, required 1 within 500 cycles");
      return;
    end
    wa = {a[63:3], 3'b000};
    r.is_load = !wr;
    r.data = ref_word(wa);
    if (wr) begin
      nw = ref_word(wa);
      for (int b = 0; b < 8; b++) if (ws[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
      ref_w[wa] = nw;
    end
    resp_q.push_back(r);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = ws;
    @(posedge clk);
    #1 acc = cyc;
    req_valid = 1'b0;
    if (snp) begin
      snoop_inv = 1'b1;
      snoop_inv_addr = snp_a;
      @(posedge clk);
      #1 snoop_inv = 1'b0;
    end
    guard = 0;
    while (resp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (resp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_wait: got no response, required one within 500 cycles");
      resp_q.delete();
      return;
    end
    lat = last_resp_cyc - acc + 1;
  endtask

  task automatic snoop_pulse(input logic [63:0] a);
    @(negedge clk);
    snoop_inv = 1'b1;
    snoop_inv_addr = a;
    @(negedge clk);
    snoop_inv = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    snoop_inv = 1'b0; snoop_inv_addr = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 7;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b, required 1", req_ready); end
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b, required 0", resp_valid); end
    if (resp_rdata !== '0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h, required 0", resp_rdata); end
    if (mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid: got %b, required 0", mem_cmd_valid); end
    if (mem_cmd_rready !== 1'b0) begin n_bad++; $display("FAIL rst_rready: got %b, required 0", mem_cmd_rready); end
    if (mem_cmd_addr !== '0) begin n_bad++; $display("FAIL rst_cmd_addr: got %h, required 0", mem_cmd_addr); end
    if (mem_cmd_data !== '0) begin n_bad++; $display("FAIL rst_cmd_data: got %h, required 0", mem_cmd_data); end
    reset = 1'b0;
  endtask

  task automatic test_clean_miss();
    int lat;
    cmd_q.push_back(mk_cmd(1'b0, 64'h1000));
    do_req(1'b0, 64'h1000, '0, '0, 1'b0, '0, lat);
    n_cmp += 2;
    if (lat < 4) begin n_bad++; $display("FAIL miss_latency: got %0d, required >= 4", lat); end
    if (cmd_q.size() != 0) begin n_bad++; $display("FAIL miss_cmds: got %0d pending, required 0", cmd_q.size()); end
    cmd_q.delete();
  endtask

  task automatic test_hit();
    int lat, c0;
    c0 = cmd_cnt;
    do_req(1'b0, 64'h1000, '0, '0, 1'b0, '0, lat);
    n_cmp += 2;
    if (lat != 1) begin n_bad++; $display("FAIL hit_latency: got %0d, required 1", lat); end
    if (cmd_cnt != c0) begin n_bad++; $display("FAIL hit_cmds: got %0d commands, required 0", cmd_cnt - c0); end
  endtask

  task automatic test_store_hit();
    int lat;
    do_req(1'b1, 64'h1008, 64'h1122_3344_5566_7788, 8'h0F, 1'b0, '0, lat);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL store_latency: got %0d, required 1", lat); end
    do_req(1'b0, 64'h1008, '0, '0, 1'b0, '0, lat);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL store_reload_latency: got %0d, required 1", lat); end
  endtask

  task automatic test_dirty_evict();
    int lat;
    cmd_q.push_back(mk_cmd(1'b1, 64'h1000));
    cmd_q.push_back(mk_cmd(1'b0, 64'h2000));
    do_req(1'b0, 64'h2000, '0, '0, 1'b0, '0, lat);
    n_cmp++;
    if (cmd_q.size() != 0) begin n_bad++; $display("FAIL evict_cmds: got %0d pending, required 0", cmd_q.size()); end
    cmd_q.delete();
    // Reload the written-back line: merged data must come back from the bus.
    cmd_q.push_back(mk_cmd(1'b0, 64'h1000));
    do_req(1'b0, 64'h1008, '0, '0, 1'b0, '0, lat);
    n_cmp++;
    if (cmd_q.size() != 0) begin n_bad++; $display("FAIL refetch_cmds: got %0d pending, required 0", cmd_q.size()); end
    cmd_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [63:0] bases [4];
    logic [63:0] a;
    int lat;
    bases[0] = 64'h4000; bases[1] = 64'h8000; bases[2] = 64'h4040; bases[3] = 64'hC000;
    chk_cmds = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a = bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 7) * 8);
      do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom_range(1, 255)),
             1'b0, '0, lat);
    end
    chk_cmds = 1'b1;
    cmd_q.delete();
  endtask

  task automatic test_snoop();
    int lat, c0;
    chk_cmds = 1'b0;
    do_req(1'b0, 64'h1000, '0, '0, 1'b0, '0, lat);
    chk_cmds = 1'b1;
    snoop_pulse(64'h3000);
    do_req(1'b0, 64'h1000, '0, '0, 1'b0, '0, lat);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL snoop_other_tag: got latency %0d, required 1", lat); end
    snoop_pulse(64'h1000);
    c0 = cmd_cnt;
`ifdef L1_DCACHE_SNOOP_INV_EN
    cmd_q.push_back(mk_cmd(1'b0, 64'h1000));
    do_req(1'b0, 64'h1000, '0, '0, 1'b0, '0, lat);
    n_cmp += 2;
    if (lat < 4) begin n_bad++; $display("FAIL snoop_miss: got latency %0d, required >= 4", lat); end
    if (cmd_q.size() != 0) begin n_bad++; $display("FAIL snoop_miss_cmds: got %0d pending, required 0", cmd_q.size()); end
    cmd_q.delete();
`else
    do_req(1'b0, 64'h1000, '0, '0, 1'b0, '0, lat);
    n_cmp += 2;
    if (lat != 1) begin n_bad++; $display("FAIL snoop_ignored: got latency %0d, required 1", lat); end
    if (cmd_cnt != c0) begin n_bad++; $display("FAIL snoop_ignored_cmds: got %0d, required 0", cmd_cnt - c0); end
`endif
  endtask

  task automatic test_snoop_coincident();
    int lat;
`ifdef L1_DCACHE_SNOOP_INV_EN
    cmd_q.push_back(mk_cmd(1'b0, 64'h1000));
    do_req(1'b0, 64'h1000, '0, '0, 1'b1, 64'h1000, lat);
    n_cmp += 2;
    if (lat < 4) begin n_bad++; $display("FAIL coinc_clean: got latency %0d, required >= 4", lat); end
    if (cmd_q.size() != 0) begin n_bad++; $display("FAIL coinc_clean_cmds: got %0d pending, required 0", cmd_q.size()); end
    cmd_q.delete();
    do_req(1'b1, 64'h1010, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0, '0, lat);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL coinc_store: got latency %0d, required 1", lat); end
    // Dirty line is dropped: no write-back, the load sees bus memory.
    for (int w = 0; w < 8; w++) ref_w.delete(64'h1000 + 64'(w * 8));
    cmd_q.push_back(mk_cmd(1'b0, 64'h1000));
    do_req(1'b0, 64'h1010, '0, '0, 1'b1, 64'h1000, lat);
    n_cmp += 2;
    if (lat < 4) begin n_bad++; $display("FAIL coinc_dirty: got latency %0d, required >= 4", lat); end
    if (cmd_q.size() != 0) begin n_bad++; $display("FAIL coinc_dirty_cmds: got %0d pending, required 0", cmd_q.size()); end
    cmd_q.delete();
`else
    do_req(1'b0, 64'h1000, '0, '0, 1'b1, 64'h1000, lat);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL coinc_ignored: got latency %0d, required 1", lat); end
    do_req(1'b1, 64'h1010, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0, '0, lat);
    do_req(1'b0, 64'h1010, '0, '0, 1'b1, 64'h1000, lat);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL coinc_dirty_ignored: got latency %0d, required 1", lat); end
`endif
  endtask

  task automatic test_reset_mid_miss();
    int lat, guard;
    chk_cmds = 1'b0;
    stall_fill = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h6040;
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!mem_cmd_rready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!mem_cmd_rready) begin n_bad++; $display("FAIL reach_fill_wait: got rready=0, required 1"); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (mem_cmd_rready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rready: got %b, required 0", mem_cmd_rready); end
    if (mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_cmd_valid: got %b, required 0", mem_cmd_valid); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_req_ready: got %b, required 1", req_ready); end
    reset = 1'b0;
    abort_fill = 1'b1;
    stall_fill = 1'b0;
    repeat (6) @(negedge clk);
    abort_fill = 1'b0;
    ref_w.delete();
    chk_cmds = 1'b1;
    cmd_q.delete();
    cmd_q.push_back(mk_cmd(1'b0, 64'h1000));
    do_req(1'b0, 64'h1000, '0, '0, 1'b0, '0, lat);
    n_cmp += 2;
    if (lat < 4) begin n_bad++; $display("FAIL post_reset_miss: got latency %0d, required >= 4", lat); end
    if (cmd_q.size() != 0) begin n_bad++; $display("FAIL post_reset_cmds: got %0d pending, required 0", cmd_q.size()); end
    cmd_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_miss();
    test_hit();
    test_store_hit();
    test_dirty_evict();
    test_back_to_back();
    test_snoop();
    test_snoop_coincident();
    test_reset_mid_miss();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
